// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared opcodes, FSM encoding and flag indices for the execute stage
package ex_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_NOR = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd6;
    localparam logic [3:0] OP_LHB = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } ex_state_t;

    localparam int FLAG_N    = 0;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_V    = 2;
    localparam int NUM_FLAGS = 3;

endpackage

// File: rtl/ex_mul_iter.sv
// rtl/ex_mul_iter.sv - iterative shift-add unsigned multiplier, one multiplier bit per cycle
module ex_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;

    // done marks the cycle whose edge retires the final multiplier bit
    assign done    = busy && (cnt_q == CW'(WIDTH - 1));
    assign product = acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, mcand_in};
            mplier_q <= mplier_in;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
        end else if (busy) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// rtl/ex_stage_pipe.sv - execute stage: saturating ALU, iterative MUL, PC adders, flag state
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OFF_W = 13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          p0,
    input  logic [WIDTH-1:0]          p1,
    input  logic [WIDTH-1:0]          sext_in,
    input  logic                      src1sel,
    input  logic [3:0]                alu_op,
    input  logic [$clog2(WIDTH)-1:0]  shamt,
    input  logic                      flag_we,
    input  logic [WIDTH-1:0]          pc,
    input  logic [OFF_W-1:0]          offset,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          alu_result,
    output logic [WIDTH-1:0]          add_result,
    output logic [WIDTH-1:0]          jump_to,
    output logic                      V,
    output logic                      Z,
    output logic                      N
);

    localparam int HALF = WIDTH / 2;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    ex_state_t state_q, state_nxt;

    logic [WIDTH-1:0]     src1, alu_res;
    logic                 alu_v;
    logic [WIDTH:0]       sum_ext, dif_ext;
    logic [WIDTH-1:0]     add_nxt, jump_nxt;
    logic                 accept, accept_mul, load_now, load_mul, load;
    logic [WIDTH-1:0]     pend_add_q, pend_jump_q;
    logic                 pend_fwe_q;
    logic                 mul_busy, mul_done;
    logic [2*WIDTH-1:0]   mul_product;
    logic [NUM_FLAGS-1:0] flags_q;
    logic [WIDTH-1:0]     ld_res, ld_add, ld_jump;
    logic                 ld_v, ld_fwe;

    assign in_ready   = (state_q == ST_IDLE) && !mul_busy && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready && !flush;
    assign accept_mul = accept && (alu_op == OP_MUL);
    assign load_now   = accept && !accept_mul;
    assign load_mul   = (state_q == ST_DONE) && !flush;
    assign load       = load_now || load_mul;

    assign add_nxt  = pc + sext_in;
    assign jump_nxt = pc + {{(WIDTH-OFF_W){offset[OFF_W-1]}}, offset};

    // One guard bit on the sum/difference exposes signed overflow as a sign-bit disagreement
    always_comb begin
        src1    = src1sel ? sext_in : p1;
        sum_ext = {p0[WIDTH-1], p0} + {src1[WIDTH-1], src1};
        dif_ext = {p0[WIDTH-1], p0} - {src1[WIDTH-1], src1};
        alu_v   = 1'b0;
        alu_res = src1;
        case (alu_op)
            OP_ADD: begin
                alu_v   = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
                alu_res = alu_v ? (sum_ext[WIDTH] ? SMIN : SMAX) : sum_ext[WIDTH-1:0];
            end
            OP_SUB: begin
                alu_v   = dif_ext[WIDTH] ^ dif_ext[WIDTH-1];
                alu_res = alu_v ? (dif_ext[WIDTH] ? SMIN : SMAX) : dif_ext[WIDTH-1:0];
            end
            OP_AND:  alu_res = p0 & src1;
            OP_NOR:  alu_res = ~(p0 | src1);
            OP_SLL:  alu_res = p0 << shamt;
            OP_SRL:  alu_res = p0 >> shamt;
            OP_SRA:  alu_res = $signed(p0) >>> shamt;
            OP_LHB:  alu_res = {src1[HALF-1:0], p0[HALF-1:0]};
            default: alu_res = src1;
        endcase
    end

    always_comb begin
        ld_res  = alu_res;
        ld_v    = alu_v;
        ld_add  = add_nxt;
        ld_jump = jump_nxt;
        ld_fwe  = flag_we && (alu_op <= OP_MUL);
        if (load_mul) begin
            ld_res  = mul_product[WIDTH-1:0];
            ld_v    = |mul_product[2*WIDTH-1:WIDTH];
            ld_add  = pend_add_q;
            ld_jump = pend_jump_q;
            ld_fwe  = pend_fwe_q;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (accept_mul) state_nxt = ST_MUL;
            ST_MUL: begin
                if (flush)         state_nxt = ST_IDLE;
                else if (mul_done) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            alu_result  <= '0;
            add_result  <= '0;
            jump_to     <= '0;
            flags_q     <= '0;
            pend_add_q  <= '0;
            pend_jump_q <= '0;
            pend_fwe_q  <= 1'b0;
        end else begin
            if (flush)          out_valid <= 1'b0;
            else if (load)      out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;

            if (load) begin
                alu_result <= ld_res;
                add_result <= ld_add;
                jump_to    <= ld_jump;
                if (ld_fwe) begin
                    flags_q[FLAG_V] <= ld_v;
                    flags_q[FLAG_Z] <= (ld_res == '0);
                    flags_q[FLAG_N] <= ld_res[WIDTH-1];
                end
            end

            // PC results are computed at acceptance and parked until the product is ready
            if (accept_mul) begin
                pend_add_q  <= add_nxt;
                pend_jump_q <= jump_nxt;
                pend_fwe_q  <= flag_we;
            end
        end
    end

    assign V = flags_q[FLAG_V];
    assign Z = flags_q[FLAG_Z];
    assign N = flags_q[FLAG_N];

    ex_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (accept_mul),
        .abort     (flush),
        .mcand_in  (p0),
        .mplier_in (src1),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (mul_product)
    );

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb/tb_ex_stage_pipe.sv - self-checking bench with a transaction-level reference model
module tb_ex_stage_pipe;

    localparam int W  = 16;
    localparam int OW = 13;

    logic              clk, rst, in_valid, in_ready, src1sel, flag_we, flush;
    logic              out_valid, out_ready, V, Z, N;
    logic [W-1:0]      p0, p1, sext_in, pc, alu_result, add_result, jump_to;
    logic [3:0]        alu_op;
    logic [$clog2(W)-1:0] shamt;
    logic [OW-1:0]     offset;

    int errors = 0;
    int checks = 0;

    ex_stage_pipe #(.WIDTH(W), .OFF_W(OW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .p0(p0), .p1(p1), .sext_in(sext_in), .src1sel(src1sel), .alu_op(alu_op),
        .shamt(shamt), .flag_we(flag_we), .pc(pc), .offset(offset), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .add_result(add_result), .jump_to(jump_to), .V(V), .Z(Z), .N(N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed { logic [W-1:0] res; logic v; } alu_t;

    // Reference arithmetic on wide integers: saturation and overflow from value ranges
    function automatic alu_t ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int sh);
        alu_t o;
        longint sa, sb, r, lim, half;
        lim  = 1; lim = lim << (W - 1);
        half = 1; half = half << (W / 2);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        o.v = 1'b0;
        o.res = b;
        case (op)
            4'd0, 4'd1: begin
                r = (op == 4'd0) ? sa + sb : sa - sb;
                if (r > lim - 1)   begin o.res = W'(lim - 1); o.v = 1'b1; end
                else if (r < -lim) begin o.res = W'(-lim);    o.v = 1'b1; end
                else               o.res = W'(r);
            end
            4'd2: o.res = a & b;
            4'd3: o.res = ~(a | b);
            4'd4: o.res = a << sh;
            4'd5: o.res = a >> sh;
            4'd6: o.res = W'(sa >>> sh);
            4'd7: o.res = W'((longint'(b) % half) * half + longint'(a) % half);
            4'd8: begin
                r = longint'(a) * longint'(b);
                o.res = W'(r);
                o.v = (r >= 2 * lim);
            end
            default: o.res = b;
        endcase
        return o;
    endfunction

    // Model state: visible results plus a countdown for an outstanding multiply
    logic          model_live = 1'b0;
    logic          m_valid, m_v, m_z, m_n, pm_v, pm_fwe;
    logic [W-1:0]  m_alu, m_add, m_jump, pm_res, pm_add, pm_jump;
    int            m_left;

    task automatic commit(input logic [W-1:0] res, input logic v, input logic [W-1:0] ad,
                          input logic [W-1:0] jt, input logic fwe);
        m_valid = 1'b1;
        m_alu = res; m_add = ad; m_jump = jt;
        if (fwe) begin
            m_v = v; m_z = (res == '0); m_n = res[W-1];
        end
    endtask

    task automatic model_step();
        alu_t r;
        logic rdy, loaded;
        logic [W-1:0] s1, ad, jt;
        loaded = 1'b0;
        if (rst) begin
            model_live = 1'b1;
            m_valid = 0; m_v = 0; m_z = 0; m_n = 0;
            m_alu = '0; m_add = '0; m_jump = '0; m_left = 0;
        end else if (model_live) begin
            rdy = (m_left == 0) && (!m_valid || out_ready);
            if (flush) begin
                m_valid = 1'b0;
                m_left = 0;
            end else begin
                if (m_left == 1) begin
                    m_left = 0;
                    commit(pm_res, pm_v, pm_add, pm_jump, pm_fwe);
                    loaded = 1'b1;
                end else if (m_left > 1) begin
                    m_left--;
                end else if (in_valid && rdy) begin
                    s1 = src1sel ? sext_in : p1;
                    r  = ref_alu(alu_op, p0, s1, int'(shamt));
                    ad = W'(longint'(pc) + longint'(sext_in));
                    jt = W'(longint'(pc) + longint'($signed(offset)));
                    if (alu_op == 4'd8) begin
                        m_left = W + 1;
                        pm_res = r.res; pm_v = r.v; pm_add = ad; pm_jump = jt; pm_fwe = flag_we;
                    end else begin
                        commit(r.res, r.v, ad, jt, flag_we && (alu_op <= 4'd8));
                        loaded = 1'b1;
                    end
                end
                if (!loaded && out_ready) m_valid = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            chk("in_ready",   in_ready,   (m_left == 0) && (!m_valid || out_ready));
            chk("out_valid",  out_valid,  m_valid);
            chk("alu_result", alu_result, m_alu);
            chk("add_result", add_result, m_add);
            chk("jump_to",    jump_to,    m_jump);
            chk("flags_vzn",  {V, Z, N},  {m_v, m_z, m_n});
        end
        model_step();
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] sx, input logic s1s, input logic fwe,
                         input logic [W-1:0] pcv, input logic [OW-1:0] off);
        int n;
        alu_op = op; p0 = a; p1 = b; sext_in = sx; src1sel = s1s; flag_we = fwe;
        pc = pcv; offset = off; shamt = '0; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", in_ready, 1'b1);
        sync();
        in_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        alu_t pin;
        int nr, nv;
        logic [2:0] saved_flags;

        pin = ref_alu(4'd0, 16'h7FFF, 16'h0001, 0); chk("pin_add_sat", {pin.res, pin.v}, {16'h7FFF, 1'b1});
        pin = ref_alu(4'd1, 16'h8000, 16'h0001, 0); chk("pin_sub_sat", {pin.res, pin.v}, {16'h8000, 1'b1});
        pin = ref_alu(4'd8, 16'h0100, 16'h0100, 0); chk("pin_mul_ovf", {pin.res, pin.v}, {16'h0000, 1'b1});
        pin = ref_alu(4'd6, 16'h8000, 16'h0000, 4); chk("pin_sra",     pin.res, 16'hF800);
        pin = ref_alu(4'd7, 16'h1234, 16'hABCD, 0); chk("pin_lhb",     pin.res, 16'hCD34);

        rst = 1; in_valid = 0; p0 = 0; p1 = 0; sext_in = 0; src1sel = 0; alu_op = 0;
        shamt = 0; flag_we = 0; pc = 0; offset = 0; flush = 0; out_ready = 1;
        repeat (3) sync();
        rst = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_alu",       alu_result, 16'h0000);
        chk("rst_flags",     {V, Z, N}, 3'b000);
        chk("rst_in_ready",  in_ready, 1'b1);
        sync();

        issue(4'd0, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0000, '0);
        @(negedge clk);
        chk("add_sat_valid", out_valid, 1'b1);
        chk("add_sat_res",   alu_result, 16'h7FFF);
        chk("add_sat_vzn",   {V, Z, N}, 3'b100);
        sync();

        issue(4'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 16'h0000, '0);
        @(negedge clk);
        chk("sub_zero_res", alu_result, 16'h0000);
        chk("sub_zero_z",   Z, 1'b1);
        sync();
        issue(4'd2, 16'h0003, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0000, '0);
        @(negedge clk);
        chk("and_nofwe_res", alu_result, 16'h0001);
        chk("and_nofwe_z",   Z, 1'b1);
        sync();

        issue(4'd0, 16'h0001, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 16'h0100, 13'h1FFF);
        @(negedge clk);
        chk("pc_add_result", add_result, 16'h00FE);
        chk("pc_jump_to",    jump_to,    16'h00FF);
        sync();

        issue(4'd8, 16'h0012, 16'h0034, 16'h0000, 1'b0, 1'b1, 16'h0000, '0);
        nr = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (!in_ready && !out_valid) nr++;
        end
        chk("mul_busy_cycles", nr, 17);
        @(negedge clk);
        chk("mul_valid", out_valid, 1'b1);
        chk("mul_res",   alu_result, 16'h03A8);
        chk("mul_v",     V, 1'b0);
        sync();

        repeat (3) sync();
        out_ready = 0;
        issue(4'd0, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, 16'h0000, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid",    out_valid, 1'b1);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_res",      alu_result, 16'h0003);
        end
        sync();
        out_ready = 1;
        @(negedge clk);
        chk("unstall_in_ready", in_ready, 1'b1);
        sync();
        @(negedge clk);
        chk("unstall_cleared", out_valid, 1'b0);
        sync();

        repeat (2) sync();
        @(negedge clk);
        saved_flags = {V, Z, N};
        sync();
        issue(4'd8, 16'h00FF, 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0000, '0);
        repeat (4) sync();
        flush = 1;
        sync();
        flush = 0;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_flags",    {V, Z, N}, saved_flags);
        nv = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("flush_no_result", nv, 0);
        sync();

        issue(4'd8, 16'h8001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h1234, 13'h0055);
        repeat (5) sync();
        rst = 1;
        @(negedge clk);
        sync();
        rst = 0;
        @(negedge clk);
        chk("rst_mid_outputs", {out_valid, alu_result, add_result, jump_to, V, Z, N}, '0);
        chk("rst_mid_in_ready", in_ready, 1'b1);
        sync();

        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            alu_op    = 4'($urandom_range(0, 15));
            p0        = rand_val();
            p1        = rand_val();
            sext_in   = rand_val();
            src1sel   = 1'($urandom_range(0, 1));
            shamt     = 4'($urandom_range(0, 15));
            flag_we   = ($urandom_range(0, 3) != 0);
            pc        = W'($urandom);
            offset    = OW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            sync();
        end
        rst = 0; flush = 0; in_valid = 0; out_ready = 1;
        repeat (25) sync();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
